// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit -- iterative multiply / divide unit with architectural HI/LO.
//
// Multiply: shift-add on unsigned magnitudes, MUL_STEP multiplier bits per
// cycle. Divide: restoring, one quotient bit per cycle. A single FIX cycle
// applies sign correction and the divide special cases, then writes HI/LO.
//
// Ports
//   clk                 sole clock, rising edge
//   resetn              synchronous active-low reset
//   mul_start/div_start operation requests (accepted only in IDLE, cancel low;
//                       mul_start wins if both are high)
//   op_signed           1 = two's-complement operands
//   op_a, op_b          multiplicand/multiplier or dividend/divisor
//   cancel              flush: aborts an operation in flight, blocks starts
//   mthi, mtlo, mt_data direct HI/LO writes while idle
//   busy                high whenever the FSM is not IDLE
//   done                one-cycle pulse, high together with the new HI/LO
//   hi, lo              architectural HI and LO registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mul_start,
    input  logic             div_start,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam int MUL_CYC = WIDTH / MUL_STEP;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    logic [1:0]         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    // Multiply: {partial product high half, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   mag_reg;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_orig_reg;   // raw dividend, returned in HI on /0
    logic               neg_a_reg;
    logic               neg_b_reg;
    logic               is_div_reg;
    logic               div0_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               done_reg;

    logic               start_ok;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign start_ok = (state_reg == ST_IDLE) && !cancel && (mul_start || div_start);
    assign abs_a    = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign abs_b    = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    // ---------------- multiply step ----------------
    // One shifted copy of the multiplicand per multiplier bit in this digit.
    logic [WIDTH+MUL_STEP-1:0]   pp [MUL_STEP];
    logic [WIDTH+MUL_STEP-1:0]   mul_sum;
    logic [2*WIDTH+MUL_STEP-1:0] mul_cat;
    logic [2*WIDTH-1:0]          mul_next;

    generate
        for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
            assign pp[gi] = acc_reg[gi] ? ({{MUL_STEP{1'b0}}, mag_reg} << gi) : '0;
        end
    endgenerate

    // The sum cannot exceed (2^W-1)*2^S, so W+S bits hold it exactly.
    always_comb begin
        mul_sum = {{MUL_STEP{1'b0}}, acc_reg[2*WIDTH-1:WIDTH]};
        for (int i = 0; i < MUL_STEP; i++) begin
            mul_sum = mul_sum + pp[i];
        end
        mul_cat  = {mul_sum, acc_reg[WIDTH-1:0]} >> MUL_STEP;
        mul_next = mul_cat[2*WIDTH-1:0];
    end

    // ---------------- divide step ----------------
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;

    // Partial remainder stays below the divisor, so the shifted value is
    // below twice the divisor and bit WIDTH of the trial is a clean borrow.
    always_comb begin
        div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_trial = div_shift - {1'b0, mag_reg};
        if (div_trial[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        end
    end

    // ---------------- sign correction / special cases ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Most-negative / -1 needs no special path: the magnitude quotient is
    // 2^(W-1) and, with both signs negative, it is left unnegated.
    always_comb begin
        prod_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg : acc_reg;
        if (div0_reg) begin
            quo_fix = '1;
            rem_fix = a_orig_reg;
        end else begin
            quo_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
            rem_fix = neg_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
        end
        if (is_div_reg) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mag_reg    <= '0;
            a_orig_reg <= '0;
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            is_div_reg <= 1'b0;
            div0_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        neg_a_reg  <= op_signed & op_a[WIDTH-1];
                        neg_b_reg  <= op_signed & op_b[WIDTH-1];
                        a_orig_reg <= op_a;
                        is_div_reg <= !mul_start;
                        div0_reg   <= !mul_start && (op_b == '0);
                        if (mul_start) begin
                            state_reg <= ST_MUL;
                            acc_reg   <= {{WIDTH{1'b0}}, abs_b};
                            mag_reg   <= abs_a;
                            cnt_reg   <= CNT_W'(MUL_CYC - 1);
                        end else begin
                            state_reg <= ST_DIV;
                            acc_reg   <= {{WIDTH{1'b0}}, abs_a};
                            mag_reg   <= abs_b;
                            cnt_reg   <= CNT_W'(WIDTH - 1);
                        end
                    end else begin
                        if (mthi) hi_reg <= mt_data;
                        if (mtlo) lo_reg <= mt_data;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cancel) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        acc_reg <= (state_reg == ST_MUL) ? mul_next : div_next;
                        if (cnt_reg == '0) begin
                            state_reg <= ST_FIX;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                end
                default: begin  // ST_FIX
                    state_reg <= ST_IDLE;
                    if (!cancel) begin
                        hi_reg   <= res_hi;
                        lo_reg   <= res_lo;
                        done_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit -- directed bench for muldiv_unit (32-bit, MUL_STEP 4) plus
// a WIDTH=16 sweep over MUL_STEP 1/2/4/8. Expected results come from a
// behavioural model and go through a queue that is popped at each done.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mul_start = 1'b0, div_start = 1'b0, op_signed = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, mt_data = '0;
    logic        cancel = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    // 16-bit sweep instances share one stimulus bus
    logic        s_mul = 1'b0, s_sg = 1'b0;
    logic [15:0] s_a = '0, s_b = '0;
    logic        s_busy [4];
    logic        s_done [4];
    logic [15:0] s_hi [4];
    logic [15:0] s_lo [4];

    exp_t        exp_q [$];
    logic [31:0] exp16_q [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) dut (
        .clk(clk), .resetn(resetn), .mul_start(mul_start), .div_start(div_start),
        .op_signed(op_signed), .op_a(op_a), .op_b(op_b), .cancel(cancel),
        .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
            muldiv_unit #(.WIDTH(16), .MUL_STEP(1 << gi)) u_sw (
                .clk(clk), .resetn(resetn), .mul_start(s_mul), .div_start(1'b0),
                .op_signed(s_sg), .op_a(s_a), .op_b(s_b), .cancel(1'b0),
                .mthi(1'b0), .mtlo(1'b0), .mt_data(16'h0000),
                .busy(s_busy[gi]), .done(s_done[gi]), .hi(s_hi[gi]), .lo(s_lo[gi])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_mul32(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = sg ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sg ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] ref_mul16(input logic sg, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] ea, eb;
        ea = sg ? {{16{a[15]}}, a} : {16'h0, a};
        eb = sg ? {{16{b[15]}}, b} : {16'h0, b};
        return ea * eb;
    endfunction

    // returns {hi = remainder, lo = quotient}
    function automatic logic [63:0] ref_div32(input logic sg, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (!sg) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Waits (bounded) for done, pops the scoreboard and checks the result.
    task automatic wait_result(input string tag, input int n0);
        int   n;
        logic got;
        exp_t e;
        n   = n0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (done) got = 1'b1;
        end
        e = exp_q.pop_front();
        check({tag, ".done_seen"}, 64'(got), 64'd1);
        check({tag, ".latency"}, 64'(n), 64'(e.lat));
        check({tag, ".hi"}, 64'(hi), 64'(e.hi));
        check({tag, ".lo"}, 64'(lo), 64'(e.lo));
        $display("op %s: hi=%h lo=%h latency=%0d", tag, hi, lo, n);
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic m, input logic d, input logic sg,
                         input logic [31:0] a, input logic [31:0] b, input logic with_mt);
        exp_t        e;
        logic [63:0] r;
        @(negedge clk);
        mul_start = m;
        div_start = d;
        op_signed = sg;
        op_a      = a;
        op_b      = b;
        mthi      = with_mt;
        mtlo      = with_mt;
        mt_data   = 32'hDEAD_BEEF;
        r     = m ? ref_mul32(sg, a, b) : ref_div32(sg, a, b);
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.lat = m ? 9 : 33;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        div_start = 1'b0;
        mthi      = 1'b0;
        mtlo      = 1'b0;
        // operands changing after acceptance must not matter
        op_a      = 32'h1357_9BDF;
        op_b      = 32'h0246_8ACE;
        op_signed = ~sg;
        check({tag, ".busy"}, 64'(busy), 64'd1);
        wait_result(tag, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           n;
        int           seen;
        exp_t         e;
        int           lat16 [4];
        logic [31:0]  cap16 [4];
        logic [31:0]  e16;
        logic [15:0]  dir_a [2];
        logic [15:0]  dir_b [2];

        // reset
        repeat (2) @(posedge clk);
        #1;
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // multiplies
        do_op("mul_u_max", 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("mul_s_neg", 1, 0, 1, 32'hFFFF_FFFD, 32'd5, 0);
        do_op("mul_s_min", 1, 0, 1, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("mul_u_mt",  1, 0, 0, 32'h0001_0003, 32'h0002_0007, 1);
        do_op("both_start", 1, 1, 0, 32'd6, 32'd3, 0);

        // divides
        do_op("div_s_m7_2", 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("div_u",      0, 1, 0, 32'd100, 32'd7, 0);
        do_op("div_s_7_m2", 0, 1, 1, 32'd7, 32'hFFFF_FFFE, 0);
        do_op("div_s_ovf",  0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("div_u_zero", 0, 1, 0, 32'd5, 32'd0, 0);
        do_op("div_s_zero", 0, 1, 1, 32'hFFFF_FFFB, 32'd0, 0);

        // cancel mid-divide
        @(negedge clk);
        mthi = 1'b1;
        mt_data = 32'h0000_1234;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        check("mthi.hi", 64'(hi), 64'h1234);
        @(negedge clk);
        div_start = 1'b1;
        op_a = 32'd1000;
        op_b = 32'd3;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        seen = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 10) cancel = 1'b1;
            @(posedge clk);
            #1;
            if (c == 10) cancel = 1'b0;
            if (done) seen++;
            if (c == 11) check("cancel.busy", 64'(busy), 64'd0);
        end
        check("cancel.no_done", 64'(seen), 64'd0);
        check("cancel.hi", 64'(hi), 64'h1234);
        $display("op cancel: hi=%h busy=%b done_pulses=%0d", hi, busy, seen);

        // cancel in IDLE blocks a start
        @(negedge clk);
        mul_start = 1'b1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        cancel = 1'b0;
        check("idle_cancel.busy", 64'(busy), 64'd0);
        $display("op idle_cancel: busy=%b", busy);

        // busy guards: second start and mtlo during a multiply are ignored
        @(negedge clk);
        mul_start = 1'b1;
        op_signed = 1'b0;
        op_a = 32'd3;
        op_b = 32'd4;
        e.hi = 32'h0;
        e.lo = 32'd12;
        e.lat = 9;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        n = 0;
        repeat (2) begin
            @(posedge clk);
            n++;
            #1;
        end
        mul_start = 1'b1;
        op_a = 32'd7;
        op_b = 32'd7;
        mtlo = 1'b1;
        mt_data = 32'h0000_00AA;
        @(posedge clk);
        n++;
        #1;
        mul_start = 1'b0;
        mtlo = 1'b0;
        wait_result("busy_guard", n);
        repeat (3) @(posedge clk);
        #1;
        check("busy_guard.idle", 64'(busy), 64'd0);
        check("busy_guard.lo_kept", 64'(lo), 64'd12);
        @(negedge clk);
        mtlo = 1'b1;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check("mtlo_idle.lo", 64'(lo), 64'hAA);
        $display("op mtlo_idle: lo=%h", lo);

        // reset mid-operation discards the result; first start right after
        @(negedge clk);
        mul_start = 1'b1;
        op_a = 32'd9;
        op_b = 32'd9;
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset.busy", 64'(busy), 64'd0);
        check("midreset.hi", 64'(hi), 64'd0);
        check("midreset.lo", 64'(lo), 64'd0);
        $display("op midreset: busy=%b hi=%h lo=%h", busy, hi, lo);
        resetn = 1'b1;
        do_op("first_after_reset", 1, 0, 1, 32'hFFFF_FF00, 32'h0000_0100, 0);

        // WIDTH=16 sweep across MUL_STEP
        dir_a[0] = 16'hFFFF; dir_b[0] = 16'hFFFF;
        dir_a[1] = 16'h8000; dir_b[1] = 16'h8000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s_sg = k[0];
            if (k < 2) begin
                s_a = dir_a[k];
                s_b = dir_b[k];
            end else begin
                s_a = 16'($urandom);
                s_b = 16'($urandom);
            end
            s_mul = 1'b1;
            exp16_q.push_back(ref_mul16(s_sg, s_a, s_b));
            @(posedge clk);
            #1;
            s_mul = 1'b0;
            for (int i = 0; i < 4; i++) begin
                lat16[i] = 0;
                cap16[i] = 32'h0;
            end
            for (int c = 1; c <= 30; c++) begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) begin
                    if (s_done[i] && lat16[i] == 0) begin
                        lat16[i] = c;
                        cap16[i] = {s_hi[i], s_lo[i]};
                    end
                end
            end
            e16 = exp16_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                check($sformatf("sweep%0d.step%0d.latency", k, 1 << i), 64'(lat16[i]), 64'(16 / (1 << i) + 1));
                check($sformatf("sweep%0d.step%0d.product", k, 1 << i), 64'(cap16[i]), 64'(e16));
            end
            $display("op sweep%0d: signed=%b a=%h b=%h product=%h latencies=%0d/%0d/%0d/%0d",
                     k, s_sg, s_a, s_b, e16, lat16[0], lat16[1], lat16[2], lat16[3]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand, HI and LO width; legal values 8..64, even.
REQ-002 The block SHALL have parameter MUL_STEP, default 4: multiplier bits consumed per cycle; legal values 1, 2, 4, 8; WIDTH mod MUL_STEP == 0.
REQ-003 The block SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-005 The block SHALL have port mul_start, input, 1: request a multiply.
REQ-006 The block SHALL have port div_start, input, 1: request a divide.
REQ-007 The block SHALL have port op_signed, input, 1: 1 = two's-complement operands, 0 = unsigned.
REQ-008 The block SHALL have ports op_a and op_b, input, WIDTH each: multiplicand/multiplier or dividend/divisor.
REQ-009 The block SHALL have port cancel, input, 1: pipeline flush; aborts the operation in flight.
REQ-010 The block SHALL have ports mthi and mtlo, input, 1 each: direct HI/LO write requests.
REQ-011 The block SHALL have port mt_data, input, WIDTH: data for mthi/mtlo.
REQ-012 The block SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 The block SHALL have port done, output, 1: single-cycle pulse on the cycle HI/LO take a mul/div result.
REQ-014 The block SHALL have ports hi and lo, output, WIDTH each: architectural HI and LO registers.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, DIV and FIX.
REQ-016 A start SHALL be accepted only in IDLE with cancel low; operands and op_signed are captured at that edge and later input changes are ignored.
REQ-017 If mul_start and div_start are both high in IDLE, mul_start SHALL win.
REQ-018 When a start is accepted, signed operands SHALL be converted to magnitudes and the operand signs latched.
REQ-019 MUL SHALL run shift-add on MUL_STEP bits per cycle for WIDTH/MUL_STEP cycles, then go to FIX.
REQ-020 DIV SHALL run a restoring divide at 1 quotient bit per cycle for WIDTH cycles, then go to FIX.
REQ-021 FIX SHALL last one cycle: apply sign correction, write HI/LO at the exit edge, assert done for that cycle, then go to IDLE.
REQ-022 Latency, counted from the accepting edge to the edge at which done is high and HI/LO are updated, SHALL be WIDTH/MUL_STEP+1 cycles for multiply and WIDTH+1 cycles for divide (9 and 33 at the defaults).
REQ-023 Multiply results SHALL be HI = product[2W-1:W] and LO = product[W-1:0], with the full 2W-bit product exact for both signed and unsigned operands.
REQ-024 Divide results SHALL be LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-025 Divide by zero SHALL give LO = all ones and HI = op_a, with latency unchanged.
REQ-026 Signed overflow (most-negative value / -1) SHALL give LO = most-negative value and HI = 0.
REQ-027 Cancel high in MUL, DIV or FIX SHALL return the FSM to IDLE at the next edge; HI/LO SHALL NOT be written and done SHALL stay low.
REQ-028 Cancel high in IDLE SHALL block any start that cycle and otherwise have no effect.
REQ-029 mthi or mtlo in IDLE with no start that cycle SHALL write mt_data to HI or LO at the next edge; both high writes both.
REQ-030 mthi/mtlo SHALL be ignored while busy or when a start is accepted in the same cycle.
REQ-031 Start pulses received while busy SHALL be ignored; no queuing.
REQ-032 hi and lo SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-033 With resetn low at an edge: FSM SHALL go to IDLE, hi = lo = 0, busy = 0, done = 0, and the iteration counter SHALL clear.
REQ-034 Reset SHALL take priority over every other input, including mid-operation, where the result is discarded.
REQ-035 The first start SHALL be accepted on the first edge with resetn high.

Verification
REQ-036 Unsigned multiply: mul_start, op_signed=0, op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> done at cycle 9, HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 Signed divide: div_start, op_signed=1, op_a=-7 (0xFFFFFFF9), op_b=2 -> done at cycle 33, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 Divide edge cases: signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; unsigned 5 / 0 -> LO=0xFFFFFFFF, HI=5.
REQ-039 Cancel mid-operation: mthi 0x1234, then div_start, cancel at cycle 10 -> no done pulse, busy low at cycle 11, HI still 0x1234.
REQ-040 Busy guards: mul_start again and mtlo 0xAA during a multiply -> both ignored; LO = first product only; mtlo accepted once idle.
REQ-041 Parameter sweep: WIDTH=16 with MUL_STEP 1, 2, 4, 8, random signed/unsigned operands vs reference model -> results exact, latencies 17, 9, 5, 3.
